// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared VGA timing defaults, counter width and the sync
//               decoder state encoding, plus a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Counter width used for column/row positions and measurements
    localparam int C_CNT_W = 10;

    // Default 640x480 timing
    localparam int C_TOTAL_COLS  = 800;
    localparam int C_TOTAL_ROWS  = 525;
    localparam int C_ACTIVE_COLS = 640;
    localparam int C_ACTIVE_ROWS = 480;
    localparam int C_LOCK_FRAMES = 2;

    typedef logic [C_CNT_W-1:0] cnt_t;

    // Decoder state encoding
    localparam logic [1:0] C_ST_SEARCH  = 2'd0;
    localparam logic [1:0] C_ST_MEASURE = 2'd1;
    localparam logic [1:0] C_ST_LOCKED  = 2'd2;

    // Increment that sticks at all-ones instead of wrapping
    function automatic cnt_t sat_inc(input cnt_t value);
        logic [C_CNT_W:0] sum;
        sum = {1'b0, value} + {{C_CNT_W{1'b0}}, 1'b1};
        return sum[C_CNT_W] ? {C_CNT_W{1'b1}} : sum[C_CNT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Registers the previous level of a sync input and produces a
//               combinational rising-edge pulse for the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic r_prev;

    // Remember last cycle's level; cleared so a high input after reset is an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= level;
        end
    end

    assign rise = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Recovers column/row position from active-high hsync/vsync
//               pulses, measures line and frame length, checks them against
//               the expected timing and reports lock / timing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int TOTAL_COLS  = C_TOTAL_COLS,
    parameter int TOTAL_ROWS  = C_TOTAL_ROWS,
    parameter int ACTIVE_COLS = C_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = C_ACTIVE_ROWS,
    parameter int LOCK_FRAMES = C_LOCK_FRAMES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ihsync,
    input  logic               ivsync,
    output logic [C_CNT_W-1:0] col,
    output logic [C_CNT_W-1:0] row,
    output logic               frame_start,
    output logic               active,
    output logic               locked,
    output logic               timing_error,
    output logic [C_CNT_W-1:0] meas_cols,
    output logic [C_CNT_W-1:0] meas_rows
);

    // Expected lengths compared against the one-bit-wider count+1
    localparam logic [C_CNT_W:0]   C_TC = TOTAL_COLS[C_CNT_W:0];
    localparam logic [C_CNT_W:0]   C_TR = TOTAL_ROWS[C_CNT_W:0];
    localparam logic [C_CNT_W-1:0] C_AC = ACTIVE_COLS[C_CNT_W-1:0];
    localparam logic [C_CNT_W-1:0] C_AR = ACTIVE_ROWS[C_CNT_W-1:0];

    // Good-frame counter wide enough to hold LOCK_FRAMES (at least 2 bits)
    localparam int                C_GW     = $clog2(LOCK_FRAMES + 1) + 1;
    localparam logic [C_GW-1:0]   C_LOCK_N = LOCK_FRAMES[C_GW-1:0];

    logic              w_hs_rise;
    logic              w_vs_rise;
    logic [C_CNT_W:0]  w_col_p1;
    logic [C_CNT_W:0]  w_row_p1;
    logic              w_checking;
    logic              w_mismatch;
    logic [1:0]        r_state;
    logic [C_GW-1:0]   r_good_cnt;
    logic [C_GW-1:0]   w_good_inc;

    sync_edge_detect u_hs_edge (
        .clock (clock),
        .reset (reset),
        .level (ihsync),
        .rise  (w_hs_rise)
    );

    sync_edge_detect u_vs_edge (
        .clock (clock),
        .reset (reset),
        .level (ivsync),
        .rise  (w_vs_rise)
    );

    // Unsaturated count+1 so a line/frame that ran past 1023 never matches
    assign w_col_p1   = {1'b0, col} + {{C_CNT_W{1'b0}}, 1'b1};
    assign w_row_p1   = {1'b0, row} + {{C_CNT_W{1'b0}}, 1'b1};
    assign w_good_inc = r_good_cnt + {{(C_GW-1){1'b0}}, 1'b1};
    assign w_checking = (r_state != C_ST_SEARCH);

    // Wrong line length, wrong frame length, vsync edge off a line start,
    // or a line/frame running one past its expected end without an edge
    assign w_mismatch = w_checking & (
           (w_hs_rise & (w_col_p1 != C_TC))
         | (w_vs_rise & (w_row_p1 != C_TR))
         | (w_vs_rise & ~w_hs_rise)
         | (~w_hs_rise & (w_col_p1 == C_TC))
         | (w_hs_rise & ~w_vs_rise & (w_row_p1 == C_TR)));

    assign locked = (r_state == C_ST_LOCKED);
    assign active = locked & (col < C_AC) & (row < C_AR);

    // Position counters, line/frame measurements and the frame-start strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            meas_cols   <= '0;
            meas_rows   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_vs_rise;
            if (w_hs_rise) begin
                col       <= '0;
                meas_cols <= sat_inc(col);
            end else begin
                col <= sat_inc(col);
            end
            if (w_vs_rise) begin
                row       <= '0;
                meas_rows <= sat_inc(row);
            end else if (w_hs_rise) begin
                row <= sat_inc(row);
            end
        end
    end

    // Lock state machine: a mismatch always wins over frame counting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= C_ST_SEARCH;
            r_good_cnt   <= '0;
            timing_error <= 1'b0;
        end else begin
            timing_error <= w_mismatch;
            case (r_state)
                C_ST_SEARCH: begin
                    if (w_vs_rise) begin
                        r_state    <= C_ST_MEASURE;
                        r_good_cnt <= '0;
                    end
                end
                C_ST_MEASURE: begin
                    if (w_mismatch) begin
                        r_state <= C_ST_SEARCH;
                    end else if (w_vs_rise) begin
                        r_good_cnt <= w_good_inc;
                        if (w_good_inc == C_LOCK_N) begin
                            r_state <= C_ST_LOCKED;
                        end
                    end
                end
                C_ST_LOCKED: begin
                    if (w_mismatch) begin
                        r_state <= C_ST_SEARCH;
                    end
                end
                default: begin
                    r_state <= C_ST_SEARCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Randomised and directed stimulus for vga_sync_decoder with a
//               timestamp-based reference model. Two instances share the
//               inputs: one with LOCK_FRAMES=2, one with LOCK_FRAMES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    // Reduced timing keeps whole frames cheap to simulate
    localparam int TC = 20;
    localparam int AC = 14;
    localparam int TR = 12;
    localparam int AR = 8;
    localparam int F  = TC * TR;

    logic clock = 1'b0;
    logic reset;
    logic ihsync;
    logic ivsync;

    logic [9:0] d_col [2];
    logic [9:0] d_row [2];
    logic [9:0] d_mc  [2];
    logic [9:0] d_mr  [2];
    logic       d_fs  [2];
    logic       d_act [2];
    logic       d_lck [2];
    logic       d_te  [2];

    always #5 clock = ~clock;

    vga_sync_decoder #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .LOCK_FRAMES(2)
    ) u_dut0 (
        .clock(clock), .reset(reset), .ihsync(ihsync), .ivsync(ivsync),
        .col(d_col[0]), .row(d_row[0]), .frame_start(d_fs[0]), .active(d_act[0]),
        .locked(d_lck[0]), .timing_error(d_te[0]), .meas_cols(d_mc[0]), .meas_rows(d_mr[0])
    );

    vga_sync_decoder #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .LOCK_FRAMES(1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .ihsync(ihsync), .ivsync(ivsync),
        .col(d_col[1]), .row(d_row[1]), .frame_start(d_fs[1]), .active(d_act[1]),
        .locked(d_lck[1]), .timing_error(d_te[1]), .meas_cols(d_mc[1]), .meas_rows(d_mr[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time stamps of the last line start instead of counters
    int cyc = 0;
    bit m_ph, m_pv;
    int m_th   [2];   // edge index of last hsync rise or reset
    int m_nh   [2];   // hsync rises since last vsync rise
    int m_mc   [2];
    int m_mr   [2];
    int m_mode [2];   // 0 search, 1 measure, 2 locked
    int m_cnt  [2];
    bit m_fs   [2];
    bit m_te   [2];
    int lock_n [2] = '{2, 1};

    // Event tallies
    int te_cnt [2];
    int fs_cnt [2];
    int lk_cnt [2];

    // Sync source position and distortions
    int sx, sy, v_shift;
    bit v_kill;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat10(input int x);
        return (x > 1023) ? 1023 : x;
    endfunction

    task automatic model_update(input bit h, input bit v, input bit r);
        bit hr, vr, err;
        int cc, cr;
        cyc++;
        if (r) begin
            m_ph = 1'b0;
            m_pv = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_th[i] = cyc; m_nh[i] = 0; m_mc[i] = 0; m_mr[i] = 0;
                m_fs[i] = 1'b0; m_te[i] = 1'b0; m_mode[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            hr = h && !m_ph;
            vr = v && !m_pv;
            m_ph = h;
            m_pv = v;
            for (int i = 0; i < 2; i++) begin
                cc  = sat10(cyc - 1 - m_th[i]);
                cr  = sat10(m_nh[i]);
                err = (m_mode[i] != 0) &&
                      ((hr && (cc + 1 != TC)) || (vr && (cr + 1 != TR)) || (vr && !hr) ||
                       (!hr && (cc == TC - 1)) || (hr && !vr && (cr == TR - 1)));
                m_te[i] = err;
                if (m_mode[i] == 0) begin
                    if (vr) begin m_mode[i] = 1; m_cnt[i] = 0; end
                end else if (err) begin
                    m_mode[i] = 0;
                end else if (m_mode[i] == 1 && vr) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == lock_n[i]) m_mode[i] = 2;
                end
                if (hr) begin
                    m_mc[i] = sat10(cc + 1);
                    m_th[i] = cyc;
                    if (!vr) m_nh[i]++;
                end
                if (vr) begin
                    m_mr[i] = sat10(cr + 1);
                    m_nh[i] = 0;
                end
                m_fs[i] = vr;
            end
        end
    endtask

    task automatic check_outputs();
        int ec, er;
        bit el;
        for (int i = 0; i < 2; i++) begin
            ec = sat10(cyc - m_th[i]);
            er = sat10(m_nh[i]);
            el = (m_mode[i] == 2);
            chk(i == 0 ? "col0" : "col1", int'(d_col[i]), ec);
            chk(i == 0 ? "row0" : "row1", int'(d_row[i]), er);
            chk(i == 0 ? "frame_start0" : "frame_start1", int'(d_fs[i]), int'(m_fs[i]));
            chk(i == 0 ? "locked0" : "locked1", int'(d_lck[i]), int'(el));
            chk(i == 0 ? "active0" : "active1", int'(d_act[i]), int'(el && ec < AC && er < AR));
            chk(i == 0 ? "timing_error0" : "timing_error1", int'(d_te[i]), int'(m_te[i]));
            chk(i == 0 ? "meas_cols0" : "meas_cols1", int'(d_mc[i]), m_mc[i]);
            chk(i == 0 ? "meas_rows0" : "meas_rows1", int'(d_mr[i]), m_mr[i]);
            if (d_te[i]) te_cnt[i]++;
            if (d_fs[i]) fs_cnt[i]++;
            if (d_lck[i]) lk_cnt[i]++;
        end
    endtask

    // One clock: drive, clock edge, advance model, sample 1 ns later
    task automatic step(input logic h, input logic v, input logic r);
        ihsync = h;
        ivsync = v;
        reset  = r;
        @(posedge clock);
        model_update(h, v, r);
        #1;
        check_outputs();
    endtask

    function automatic logic src_h();
        return logic'(sx < AC);
    endfunction

    function automatic logic src_v();
        if (v_kill) return 1'b0;
        if (sy == 0 && sx < v_shift) return 1'b0;
        return logic'(sy < AR);
    endfunction

    task automatic advance();
        sx++;
        if (sx == TC) begin
            sx = 0;
            sy = (sy == TR - 1) ? 0 : sy + 1;
        end
    endtask

    task automatic src_run(input int n);
        for (int k = 0; k < n; k++) begin
            step(src_h(), src_v(), 1'b0);
            advance();
        end
    endtask

    // Run the source until it is about to present pixel (x,y), bounded by a frame
    task automatic src_goto(input int x, input int y);
        for (int k = 0; k < F && !(sx == x && sy == y); k++) src_run(1);
    endtask

    initial begin
        int base, first_col;
        bit found;
        ihsync = 1'b0; ivsync = 1'b0; reset = 1'b1;
        sx = 0; sy = 0; v_shift = 0; v_kill = 1'b0;
        for (int i = 0; i < 2; i++) begin te_cnt[i] = 0; fs_cnt[i] = 0; lk_cnt[i] = 0; end

        // Reset, then lock on a clean source starting at pixel (0,0)
        repeat (10) step(1'b0, 1'b0, 1'b1);
        chk("reset_locked", int'(d_lck[0]), 0);
        src_run(2 * F);
        chk("t1_locked_before", int'(d_lck[0]), 0);
        src_run(1);
        chk("t1_locked", int'(d_lck[0]), 1);
        chk("t1_meas_cols", int'(d_mc[0]), TC);
        chk("t1_meas_rows", int'(d_mr[0]), TR);
        chk("t1_no_error", te_cnt[0], 0);

        // One short line drops lock, two good frames relock
        src_run(5);
        advance();
        base = te_cnt[0];
        src_run(TC);
        chk("t2_error_pulses", te_cnt[0] - base, 1);
        chk("t2_unlocked", int'(d_lck[0]), 0);
        src_run(3 * F);
        chk("t2_relocked", int'(d_lck[0]), 1);

        // hsync held low past the line end and past counter saturation
        src_goto(AC, sy);
        first_col = -1;
        for (int k = 0; k < 1100; k++) begin
            step(1'b0, src_v(), 1'b0);
            if (d_te[0] && first_col < 0) first_col = int'(d_col[0]);
        end
        chk("t3_error_col", first_col, TC);
        chk("t3_col_saturated", int'(d_col[0]), 1023);
        chk("t3_unlocked", int'(d_lck[0]), 0);
        found = 1'b0;
        for (int k = 0; k < 2 * TC && !found; k++) begin
            src_run(1);
            found = (d_col[0] == 10'd0);
        end
        chk("t3_hs_resume", int'(found), 1);
        chk("t3_meas_cols_sat", int'(d_mc[0]), 1023);
        src_run(3 * F);
        chk("t3_relocked", int'(d_lck[0]), 1);

        // Position recovery at the active-area corners, one frame_start per frame
        src_goto(AC - 1, AR - 1);
        src_run(1);
        chk("t4_col_last", int'(d_col[0]), AC - 1);
        chk("t4_row_last", int'(d_row[0]), AR - 1);
        chk("t4_active_last", int'(d_act[0]), 1);
        src_goto(AC, 0);
        src_run(1);
        chk("t4_col_blank", int'(d_col[0]), AC);
        chk("t4_active_blank", int'(d_act[0]), 0);
        base = fs_cnt[0];
        src_run(3 * F);
        chk("t4_frame_starts", fs_cnt[0] - base, 3);

        // Reset mid-frame while locked
        src_run(F / 2 + 3);
        chk("t5_locked_before", int'(d_lck[0]), 1);
        step(src_h(), src_v(), 1'b1);
        advance();
        chk("t5_col", int'(d_col[0]), 0);
        chk("t5_row", int'(d_row[0]), 0);
        chk("t5_locked", int'(d_lck[0]), 0);
        chk("t5_meas_cols", int'(d_mc[0]), 0);
        chk("t5_meas_rows", int'(d_mr[0]), 0);
        src_run(4 * F);
        chk("t5_relocked", int'(d_lck[0]), 1);

        // vsync rising a few pixels into the line: errors every frame, never locks
        chk("t6_locked_before", int'(d_lck[1]), 1);
        v_shift = 5;
        base = te_cnt[1];
        src_run(F);
        lk_cnt[1] = 0;
        src_run(3 * F);
        chk("t6_errors", te_cnt[1] - base, 4);
        chk("t6_never_locked", lk_cnt[1], 0);
        v_shift = 0;

        // Random disturbances, all checked cycle by cycle against the model
        for (int e = 0; e < 25; e++) begin
            case ($urandom_range(0, 5))
                0: src_run(int'($urandom_range(F / 2, 2 * F)));
                1: begin advance(); src_run(TC); end
                2: begin
                    logic hh;
                    hh = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 40)) step(hh, src_v(), 1'b0);
                end
                3: repeat ($urandom_range(1, 20))
                       step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                4: repeat ($urandom_range(1, 3)) begin
                       step(src_h(), src_v(), 1'b1);
                       advance();
                   end
                default: begin
                    v_shift = int'($urandom_range(1, TC - 1));
                    src_run(F);
                    v_shift = 0;
                end
            endcase
            src_run(F);
        end

        // vsync absent long enough to saturate the row counter
        v_kill = 1'b1;
        src_run(1030 * TC);
        chk("rowsat_row", int'(d_row[0]), 1023);
        chk("rowsat_unlocked", int'(d_lck[0]), 0);
        v_kill = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2 * F && !found; k++) begin
            src_run(1);
            found = d_fs[0];
        end
        chk("rowsat_vs_resume", int'(found), 1);
        chk("rowsat_meas_rows", int'(d_mr[0]), 1023);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
